mem_sram_responder: RTL

- Memory-side responder for the simple mem request interface: req, addr, we, wdata, be in; gnt, rvalid, rdata, err out.
- Sits at the far end of the AXI-to-mem bridge (behind axi_top's mem_*_o outputs) and serves as the on-chip word SRAM.
- Usable as RTL storage and as the bench memory for the bridge.
- Accepts one request per cycle. Returns exactly one response per granted request after a fixed configurable latency.

---
 rtl/mem_resp_pkg.sv | 15 +
 rtl/mem_resp_lat_pipe.sv | 31 +++
 rtl/mem_sram_responder.sv | 110 +++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared constants and helpers for the mem_sram_responder slice.
// The optional LFSR backpressure is enabled by defining MEM_RESP_STALL_EN.
package mem_resp_pkg;

    localparam int MaxLatency = 4;

    // Fibonacci LFSR, taps 4 and 3 (bits 3 and 2), shifting toward the MSB.
    localparam logic [3:0] LfsrSeed = 4'b1001;
    localparam logic [3:0] LfsrTaps = 4'b1100;

    function automatic int word_off_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/mem_resp_lat_pipe.sv
// Fixed-depth delay line for response entries; every stage resets to zero.
module mem_resp_lat_pipe #(
    parameter int Width = 34,
    parameter int Depth = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] entry,
    output logic [Width-1:0] result
);

    logic [Width-1:0] stage [Depth];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // shifts from the values present before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= entry;
            for (int i = 1; i < Depth; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign result = stage[Depth-1];

endmodule

// File: rtl/mem_sram_responder.sv
// Word SRAM responder for the mem request interface with fixed response latency.
// Define MEM_RESP_STALL_EN to add LFSR-driven grant backpressure.
module mem_sram_responder
    import mem_resp_pkg::*;
#(
    parameter int MemAddrWidth = 5,
    parameter int DataWidth    = 32,
    parameter int NumWords     = 8,
    parameter int Latency      = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    mem_req_i,
    output logic                    mem_gnt_o,
    input  logic [MemAddrWidth-1:0] mem_addr_i,
    input  logic                    mem_we_i,
    input  logic [DataWidth-1:0]    mem_wdata_i,
    input  logic [DataWidth/8-1:0]  mem_be_i,
    output logic                    mem_rvalid_o,
    output logic [DataWidth-1:0]    mem_rdata_o,
    output logic                    mem_err_o
);

    localparam int OffBits  = word_off_bits(DataWidth);
    localparam int BeWidth  = DataWidth / 8;
    localparam int IdxWidth = MemAddrWidth - OffBits;
    localparam int SelWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int Depth    = (Latency > MaxLatency) ? MaxLatency : ((Latency < 1) ? 1 : Latency);
    localparam int EntryW   = 2 + DataWidth;

    logic [DataWidth-1:0] mem_q [NumWords];
    logic [IdxWidth-1:0]  idx;
    logic [SelWidth-1:0]  word_sel;
    logic                 in_range;
    logic                 grant;
    logic                 wr_en;
    logic [DataWidth-1:0] rd_word;
    logic                 resp_err;
    logic [EntryW-1:0]    entry;
    logic [EntryW-1:0]    result;
    logic                 unused_offset;

    // Sub-word offset bits are deliberately ignored: no misalignment error.
    assign unused_offset = ^mem_addr_i[OffBits-1:0];

    assign idx      = mem_addr_i[MemAddrWidth-1:OffBits];
    assign word_sel = idx[SelWidth-1:0];
    assign in_range = (32'(idx) < 32'(NumWords));
    assign grant    = mem_req_i & mem_gnt_o;
    assign wr_en    = grant & mem_we_i & in_range;

`ifdef MEM_RESP_STALL_EN
    logic [3:0] lfsr_q;
    logic       gnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LfsrSeed;
            gnt_q  <= 1'b1;
        end else begin
            lfsr_q <= {lfsr_q[2:0], ^(lfsr_q & LfsrTaps)};
            gnt_q  <= ~(lfsr_q[0] & lfsr_q[1]);
        end
    end

    assign mem_gnt_o = gnt_q;
`else
    assign mem_gnt_o = 1'b1;
`endif

    // NOTE: the storage array is reset explicitly because the responder
    // guarantees all-zero contents after reset; this forces flops, not a RAM macro.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < NumWords; w++) begin
                mem_q[w] <= '0;
            end
        end else if (wr_en) begin
            for (int w = 0; w < NumWords; w++) begin
                if (word_sel == SelWidth'(w)) begin
                    for (int b = 0; b < BeWidth; b++) begin
                        if (mem_be_i[b]) begin
                            mem_q[w][b*8 +: 8] <= mem_wdata_i[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read data is taken from the pre-edge contents, so a same-edge write is not visible.
    assign rd_word  = (grant && !mem_we_i && in_range) ? mem_q[word_sel] : '0;
    assign resp_err = grant & ~in_range;
    assign entry    = {grant, resp_err, rd_word};

    mem_resp_lat_pipe #(
        .Width (EntryW),
        .Depth (Depth)
    ) u_lat_pipe (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .entry  (entry),
        .result (result)
    );

    assign mem_rvalid_o = result[EntryW-1];
    assign mem_err_o    = result[EntryW-2];
    assign mem_rdata_o  = result[DataWidth-1:0];

endmodule
